// File: rtl/mem_router_pkg.sv
// Shared definitions for the memory access router: state encoding,
// timeout fault data and the default main-port timeout.
package mem_router_pkg;
  localparam int          DEF_MAIN_TIMEOUT = 15;
  localparam logic [15:0] FAULT_DATA       = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_REQ  = 3'd1,
    S_DATA = 3'd2,
    M_WAIT = 3'd3,
    RESP   = 3'd4
  } state_t;
endpackage

// File: rtl/mem_timeout_counter.sv
// Counts main-port wait cycles; expired flags the last allowed wait cycle.
module mem_timeout_counter
  import mem_router_pkg::*;
#(
  parameter int LIMIT = DEF_MAIN_TIMEOUT
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [7:0] cnt;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 8'd1;
  end

  // cnt holds the number of wait cycles already completed, so the
  // LIMIT-th wait cycle is the one where cnt == LIMIT-1.
  assign expired = enable && (cnt == 8'(LIMIT - 1));
endmodule

// File: rtl/mem_access_router.sv
// Routes one CPU data access to stack RAM (fixed latency) or the main port
// (acknowledged, with timeout and a sticky fault flag).
module mem_access_router
  import mem_router_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MAIN_TIMEOUT = DEF_MAIN_TIMEOUT
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Req,
  input  logic              WE,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  input  logic              Segment,
  input  logic              FaultClr,
  output logic              Ready,
  output logic [DATA_W-1:0] RData,
  output logic              Busy,
  output logic              Fault,
  output logic              SReq,
  output logic              SWE,
  output logic [ADDR_W-1:0] SAddr,
  output logic [DATA_W-1:0] SWData,
  input  logic [DATA_W-1:0] SRData,
  output logic              MReq,
  output logic              MWE,
  output logic [ADDR_W-1:0] MAddr,
  output logic [DATA_W-1:0] MWData,
  input  logic              MAck,
  input  logic [DATA_W-1:0] MRData
);
  state_t            state, nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              tmo;
  logic              accept;

  assign accept = (state == IDLE) && Req;

  mem_timeout_counter #(.LIMIT(MAIN_TIMEOUT)) u_tmo (
    .CLK     (CLK),
    .Reset   (Reset),
    .clear   (accept && !Segment),
    .enable  (state == M_WAIT),
    .expired (tmo)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (Req) nxt = Segment ? S_REQ : M_WAIT;
      S_REQ:   nxt = S_DATA;
      S_DATA:  nxt = RESP;
      M_WAIT:  if (MAck || tmo) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      RData   <= '0;
      Fault   <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        addr_q  <= Addr;
        wdata_q <= WData;
        we_q    <= WE;
      end
      if (state == S_DATA && !we_q) RData <= SRData;
      // Ack takes priority over a timeout landing in the same cycle.
      if (state == M_WAIT && !we_q) begin
        if (MAck)     RData <= MRData;
        else if (tmo) RData <= DATA_W'(FAULT_DATA);
      end
      if (state == M_WAIT && !MAck && tmo) Fault <= 1'b1;
      else if (FaultClr)                   Fault <= 1'b0;
    end
  end

  // Port outputs are gated by state so idle ports present zeros.
  assign Ready  = (state == RESP);
  assign Busy   = (state != IDLE);
  assign SReq   = (state == S_REQ);
  assign SWE    = SReq && we_q;
  assign SAddr  = SReq ? addr_q  : '0;
  assign SWData = SReq ? wdata_q : '0;
  assign MReq   = (state == M_WAIT);
  assign MWE    = MReq && we_q;
  assign MAddr  = MReq ? addr_q  : '0;
  assign MWData = MReq ? wdata_q : '0;
endmodule

// File: tb/tb_mem_access_router.sv
// Scoreboard bench for mem_access_router: stack, main, timeout, back-to-back, reset.
module tb_mem_access_router;
  logic        CLK = 1'b0;
  logic        Reset, Req, WE, Segment, FaultClr, MAck;
  logic [15:0] Addr, WData, SRData, MRData;
  logic        Ready, Busy, Fault, SReq, SWE, MReq, MWE;
  logic [15:0] RData, SAddr, SWData, MAddr, MWData;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_rd = 16'h0000;

  typedef struct {logic [15:0] rdata; int lat;} exp_t;
  exp_t exp_q[$];

  mem_access_router dut (
    .CLK(CLK), .Reset(Reset), .Req(Req), .WE(WE), .Addr(Addr), .WData(WData),
    .Segment(Segment), .FaultClr(FaultClr), .Ready(Ready), .RData(RData),
    .Busy(Busy), .Fault(Fault), .SReq(SReq), .SWE(SWE), .SAddr(SAddr),
    .SWData(SWData), .SRData(SRData), .MReq(MReq), .MWE(MWE), .MAddr(MAddr),
    .MWData(MWData), .MAck(MAck), .MRData(MRData)
  );

  always #5 CLK = ~CLK;

  // Issues one access in cycle 0 and observes cycles 1.. until Ready (bounded).
  task automatic run_access(input logic we, input logic seg, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] rd, input int ack_at,
                            output int lat, output int mreq_n, output int sreq_n,
                            output int sreq_first, output int both,
                            output logic [15:0] port_addr, output logic [15:0] port_wdata);
    @(negedge CLK);
    Req = 1'b1; WE = we; Segment = seg; Addr = addr; WData = wdata;
    SRData = rd; MRData = rd; MAck = 1'b0;
    lat = -1; mreq_n = 0; sreq_n = 0; sreq_first = -1; both = 0;
    port_addr = 16'h0; port_wdata = 16'h0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      Req  = 1'b0;
      MAck = (c == ack_at);
      if (MReq) begin mreq_n++; port_addr = MAddr; port_wdata = MWData; end
      if (SReq) begin
        sreq_n++; port_addr = SAddr; port_wdata = SWData;
        if (sreq_first < 0) sreq_first = c;
      end
      if (SReq && MReq) both++;
      if (Ready) begin lat = c; MAck = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req = 0; WE = 0; Segment = 0; FaultClr = 0; MAck = 0;
    Addr = 0; WData = 0; SRData = 0; MRData = 0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({Ready, Busy, Fault, SReq, SWE, MReq, MWE} !== 7'b0)
      $display("FAIL reset_ctrl got=%b want=0000000", {Ready, Busy, Fault, SReq, SWE, MReq, MWE});
    checks++;
    if ({RData, SAddr, SWData, MAddr, MWData} !== 80'h0)
      $display("FAIL reset_data got=%h want=0", {RData, SAddr, SWData, MAddr, MWData});
    if ({Ready, Busy, Fault, SReq, SWE, MReq, MWE} !== 7'b0 ||
        {RData, SAddr, SWData, MAddr, MWData} !== 80'h0) errors++;
    Reset = 1'b0;
  endtask

  task automatic test_stack_read();
    int lat, mn, sn, sf, both; logic [15:0] pa, pw; exp_t e;
    exp_q.push_back('{16'hBEEF, 3});
    run_access(1'b0, 1'b1, 16'h07F0, 16'h0000, 16'hBEEF, 0, lat, mn, sn, sf, both, pa, pw);
    last_rd = 16'hBEEF;
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL stack_lat got=%0d want=%0d", lat, e.lat); end
    checks++; if (RData !== e.rdata) begin errors++; $display("FAIL stack_rdata got=%h want=%h", RData, e.rdata); end
    checks++; if (sn !== 1 || sf !== 1 || mn !== 0)
      begin errors++; $display("FAIL stack_strobe got sreq=%0d first=%0d mreq=%0d want 1/1/0", sn, sf, mn); end
    checks++; if (pa !== 16'h07F0) begin errors++; $display("FAIL stack_addr got=%h want=07f0", pa); end
    @(negedge CLK);
    checks++; if (Ready !== 1'b0 || Busy !== 1'b0)
      begin errors++; $display("FAIL stack_after got ready=%b busy=%b want 0/0", Ready, Busy); end
  endtask

  task automatic test_main_write();
    int lat, mn, sn, sf, both; logic [15:0] pa, pw; exp_t e;
    exp_q.push_back('{last_rd, 5});
    run_access(1'b1, 1'b0, 16'h8000, 16'h1234, 16'hDEAD, 4, lat, mn, sn, sf, both, pa, pw);
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL mwr_lat got=%0d want=%0d", lat, e.lat); end
    checks++; if (mn !== 4 || sn !== 0) begin errors++; $display("FAIL mwr_mreq got=%0d sreq=%0d want 4/0", mn, sn); end
    checks++; if (pw !== 16'h1234 || pa !== 16'h8000)
      begin errors++; $display("FAIL mwr_port got addr=%h data=%h want 8000/1234", pa, pw); end
    checks++; if (RData !== e.rdata) begin errors++; $display("FAIL mwr_rdata got=%h want=%h", RData, e.rdata); end
  endtask

  task automatic test_timeout();
    int lat, mn, sn, sf, both; logic [15:0] pa, pw; exp_t e;
    exp_q.push_back('{16'hFFFF, 16});
    run_access(1'b0, 1'b0, 16'h9000, 16'h0000, 16'h4321, 0, lat, mn, sn, sf, both, pa, pw);
    last_rd = 16'hFFFF;
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL tmo_lat got=%0d want=%0d", lat, e.lat); end
    checks++; if (mn !== 15) begin errors++; $display("FAIL tmo_mreq got=%0d want=15", mn); end
    checks++; if (RData !== e.rdata) begin errors++; $display("FAIL tmo_rdata got=%h want=%h", RData, e.rdata); end
    checks++; if (Fault !== 1'b1) begin errors++; $display("FAIL tmo_fault got=%b want=1", Fault); end
    @(negedge CLK); FaultClr = 1'b1;
    @(negedge CLK); FaultClr = 1'b0;
    checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL fault_clr got=%b want=0", Fault); end
  endtask

  task automatic test_ack_at_timeout();
    int lat, mn, sn, sf, both; logic [15:0] pa, pw; exp_t e;
    exp_q.push_back('{16'h5A5A, 16});
    run_access(1'b0, 1'b0, 16'h9002, 16'h0000, 16'h5A5A, 15, lat, mn, sn, sf, both, pa, pw);
    last_rd = 16'h5A5A;
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL ackedge_lat got=%0d want=%0d", lat, e.lat); end
    checks++; if (RData !== e.rdata) begin errors++; $display("FAIL ackedge_rdata got=%h want=%h", RData, e.rdata); end
    checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL ackedge_fault got=%b want=0", Fault); end
  endtask

  task automatic test_back_to_back();
    int nready = 0; int first = -1; int second = -1; exp_t e;
    @(negedge CLK);
    Req = 1'b1; WE = 1'b0; Segment = 1'b1; Addr = 16'h0100; SRData = 16'h2222;
    exp_q.push_back('{16'h2222, 3});
    exp_q.push_back('{16'h3333, 7});
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLK);
      if (c == 5) begin Req = 1'b0; SRData = 16'h3333; end
      if (Ready) begin
        nready++;
        if (first < 0) first = c; else second = c;
        e = exp_q.pop_front();
        checks++; if (c !== e.lat) begin errors++; $display("FAIL b2b_lat got=%0d want=%0d", c, e.lat); end
        checks++; if (RData !== e.rdata) begin errors++; $display("FAIL b2b_rdata got=%h want=%h", RData, e.rdata); end
      end
    end
    last_rd = 16'h3333;
    checks++; if (nready !== 2) begin errors++; $display("FAIL b2b_count got=%0d want=2", nready); end
  endtask

  task automatic test_random();
    int lat, mn, sn, sf, both; logic [15:0] pa, pw; exp_t e;
    for (int i = 0; i < 8; i++) begin
      logic we, seg; logic [15:0] rd, wd; int ack;
      we = 1'($urandom_range(0, 1)); seg = 1'($urandom_range(0, 1));
      rd = 16'($urandom); wd = 16'($urandom); ack = $urandom_range(1, 12);
      exp_q.push_back('{we ? last_rd : rd, seg ? 3 : ack + 1});
      if (!we) last_rd = rd;
      run_access(we, seg, 16'($urandom), wd, rd, ack, lat, mn, sn, sf, both, pa, pw);
      e = exp_q.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL rnd%0d_lat got=%0d want=%0d", i, lat, e.lat); end
      checks++; if (RData !== e.rdata) begin errors++; $display("FAIL rnd%0d_rdata got=%h want=%h", i, RData, e.rdata); end
      checks++; if (both !== 0 || pw !== wd)
        begin errors++; $display("FAIL rnd%0d_port got overlap=%0d wdata=%h want 0/%h", i, both, pw, wd); end
    end
  endtask

  task automatic test_reset_mid_access();
    int stray = 0;
    @(negedge CLK);
    Req = 1'b1; WE = 1'b0; Segment = 1'b0; Addr = 16'hA000; MAck = 1'b0;
    @(negedge CLK); Req = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (MReq !== 1'b1) begin errors++; $display("FAIL rst_pre got mreq=%b want=1", MReq); end
    #1 Reset = 1'b1;
    #1;
    checks++;
    if ({Ready, Busy, Fault, SReq, SWE, MReq, MWE} !== 7'b0 || {RData, MAddr} !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid got ctrl=%b rdata=%h maddr=%h want 0", {Ready, Busy, Fault, SReq, SWE, MReq, MWE}, RData, MAddr);
    end
    @(negedge CLK); Reset = 1'b0; MAck = 1'b1; MRData = 16'h7777;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (Ready || Busy) stray++;
    end
    MAck = 1'b0;
    checks++; if (stray !== 0) begin errors++; $display("FAIL rst_late_ack got=%0d busy/ready cycles want=0", stray); end
  endtask

  initial begin
    test_reset();
    test_stack_read();
    test_main_write();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_router.md
# mem_access_router

Routes a single CPU data-memory access to either the on-chip stack RAM or the external main-memory port, based on the one-bit segment decision computed for the same address. Sits directly downstream of the stack-segment address checker and upstream of both memory ports. Presents a uniform request/ready interface to the CPU, with fixed-latency stack accesses, variable-latency main accesses and a main-port timeout with a sticky fault flag.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MAIN_TIMEOUT, 15, max cycles in main-wait before fault (1..255)
- CLK  in  1  system clock, rising edge; sole clock
- Reset  in  1  asynchronous, active-high reset
- Req  in  1  CPU access request, sampled only in IDLE
- WE  in  1  1 = write, 0 = read; sampled with Req
- Addr  in  ADDR_W  access address
- WData  in  DATA_W  write data
- Segment  in  1  1 = stack RAM, 0 = main memory; combinational function of Addr, sampled with Req
- FaultClr  in  1  clears Fault
- Ready  out  1  one-cycle completion pulse
- RData  out  DATA_W  read result, registered, held until next read completion
- Busy  out  1  high whenever state ≠ IDLE
- Fault  out  1  sticky main-port timeout flag
- SReq, SWE  out  1  stack RAM strobe / write enable
- SAddr  out  ADDR_W; SWData  out  DATA_W
- SRData  in  DATA_W  stack RAM read data, valid one cycle after SReq
- MReq, MWE  out  1  main-port request (level, held until ack) / write enable
- MAddr  out  ADDR_W; MWData  out  DATA_W
- MAck  in  1  main-port acknowledge
- MRData  in  DATA_W  valid in the MAck cycle

## Operation
- States: IDLE, S_REQ, S_DATA, M_WAIT, RESP.
- IDLE: Req=1 → latch Addr, WData, WE, Segment; Segment=1 → S_REQ, Segment=0 → M_WAIT. Req=0 → stay.
- S_REQ: SReq=1, SWE=latched WE, SAddr/SWData from latches → S_DATA.
- S_DATA: read → load RData from SRData; → RESP.
- M_WAIT: MReq=1, MWE/MAddr/MWData from latches; counter increments each cycle. MAck=1 → load RData from MRData (reads only), → RESP. Counter reaching MAIN_TIMEOUT with MAck=0 → RData=16'hFFFF (reads only), Fault=1, → RESP. MAck and timeout in the same cycle → ack wins, no fault.
- RESP: Ready=1 for exactly this cycle → IDLE.
- Writes never modify RData.
- Req while Busy=1 is ignored; the CPU waits for Ready.
- MAck outside M_WAIT is ignored.
- Fault: set on timeout; cleared by FaultClr when no timeout occurs in the same cycle; set wins over clear.
- Port outputs are Moore, decoded from the state register and latches. SReq/MReq are never both high.

## Timing
- Reset (asynchronous) → state IDLE. Ready, Busy, Fault, SReq, SWE, MReq, MWE = 0; RData, latches, counter = 0; SAddr/MAddr/SWData/MWData = 0.
- Reset mid-access abandons the transaction immediately, with no Ready pulse.
- Stack access: Req high in cycle 0 → SReq in cycle 1 → RESP in cycle 3. Fixed Ready latency of 3.
- Main access: MReq from cycle 1; ack in cycle k → Ready in cycle k+1.
- Timeout: MReq high for exactly MAIN_TIMEOUT cycles, then Ready one cycle later.
- Back-to-back: the cycle after Ready is IDLE, so a new Req there is accepted. Throughput is one stack access per 4 cycles.

## Structure
- Shared package mem_router_pkg: state encoding localparams, FAULT_DATA = 16'hFFFF, default MAIN_TIMEOUT.
- One sub-module: mem_timeout_counter.
  - Inputs: clear, enable. Output: expired.
  - 8-bit counter, cleared on IDLE→M_WAIT.

## Test plan
- Stack read, Addr=16'h07F0, Segment=1, SRData=16'hBEEF a cycle after SReq → SReq in cycle 1 only, Ready in cycle 3, RData=16'hBEEF.
- Main write, Segment=0, WData=16'h1234, MAck in cycle 4 → MReq cycles 1–4, MWData=16'h1234, Ready cycle 5, RData unchanged.
- Main read with MAck never asserted → MReq high 15 cycles, Ready follows, RData=16'hFFFF, Fault=1. Then FaultClr=1 → Fault=0 next cycle.
- MAck arriving in the same cycle the counter reaches MAIN_TIMEOUT → RData=MRData, Fault stays 0.
- Req asserted during Busy, then again in the cycle after Ready → first ignored, second accepted, with no extra Ready pulse.
- Reset pulsed during M_WAIT, then MAck=1 → all outputs 0, state IDLE, late MAck produces no Ready.
